// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings and defaults for the D-stage stall unit.
package hazard_stall_unit_pkg;

  localparam int REG_W_DEF       = 5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam tuse_t TUSE_NONE = 2'd3;
  localparam tnew_t TNEW_0    = 2'd0;
  localparam tnew_t TNEW_1    = 2'd1;
  localparam tnew_t TNEW_2    = 2'd2;

  // Tnew seen one stage later: one cycle closer to forwardable, never below 0.
  function automatic tnew_t ageTnew(input tnew_t t);
    return (t == TNEW_0) ? TNEW_0 : tnew_t'(t - TNEW_1);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// D-stage hazard inputs, mult/div start strobe and the stall/busy outputs.
interface hazard_stall_unit_if #(
  parameter int REG_W = 5
);

  logic [REG_W-1:0] D_A1;
  logic [REG_W-1:0] D_A2;
  logic [1:0]       D_Tuse_rs;
  logic [1:0]       D_Tuse_rt;
  logic [REG_W-1:0] D_A3;
  logic [1:0]       D_Tnew;
  logic             D_is_md;
  logic             E_md_start;
  logic             E_md_is_div;
  logic             Stall_Data;
  logic             md_busy;

  modport master (
    output D_A1, D_A2, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, D_is_md,
    output E_md_start, E_md_is_div,
    input  Stall_Data, md_busy
  );

  modport slave (
    input  D_A1, D_A2, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, D_is_md,
    input  E_md_start, E_md_is_div,
    output Stall_Data, md_busy
  );

endinterface

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Mult/div busy counter: reloads on every start, counts down to zero.
module md_busy_counter
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] mdCnt_q;
  logic [CNT_W-1:0] mdCnt_d;

  // A new start restarts the window rather than extending the old one.
  always_comb begin
    mdCnt_d = mdCnt_q;
    if (start) begin
      mdCnt_d = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (mdCnt_q != '0) begin
      mdCnt_d = mdCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdCnt_q <= '0;
    end else begin
      mdCnt_q <= mdCnt_d;
    end
  end

  assign busy = !reset && (start || (mdCnt_q != '0));

endmodule

// File: rtl/hazard_stall_unit.sv
// Decides each cycle whether the D-stage instruction must wait, using Tuse/Tnew against shadow copies of E and M.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_unit_if.slave bus
);

  logic [REG_W-1:0] eA3_q, eA3_d;
  logic [REG_W-1:0] mA3_q, mA3_d;
  tnew_t            eTnew_q, eTnew_d;
  tnew_t            mTnew_q, mTnew_d;

  logic mdBusy;
  logic hazRsE, hazRtE, hazRsM, hazRtM;
  logic stall;

  md_busy_counter #(
    .CNT_W      (CNT_W),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .start (bus.E_md_start),
    .is_div(bus.E_md_is_div),
    .busy  (mdBusy)
  );

  // Tuse of 3 can never be below a Tnew of at most 2, so unread operands drop out naturally.
  always_comb begin
    hazRsE = (bus.D_Tuse_rs < eTnew_q) && (bus.D_A1 == eA3_q) && (eA3_q != '0);
    hazRtE = (bus.D_Tuse_rt < eTnew_q) && (bus.D_A2 == eA3_q) && (eA3_q != '0);
    hazRsM = (bus.D_Tuse_rs < mTnew_q) && (bus.D_A1 == mA3_q) && (mA3_q != '0);
    hazRtM = (bus.D_Tuse_rt < mTnew_q) && (bus.D_A2 == mA3_q) && (mA3_q != '0);
    stall  = !reset && (hazRsE || hazRtE || hazRsM || hazRtM || (bus.D_is_md && mdBusy));
  end

  // A stalled D instruction leaves a bubble in E instead of advancing.
  always_comb begin
    eA3_d   = stall ? '0 : bus.D_A3;
    eTnew_d = stall ? TNEW_0 : tnew_t'(bus.D_Tnew);
    mA3_d   = eA3_q;
    mTnew_d = ageTnew(eTnew_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eA3_q   <= '0;
      eTnew_q <= TNEW_0;
      mA3_q   <= '0;
      mTnew_q <= TNEW_0;
    end else begin
      eA3_q   <= eA3_d;
      eTnew_q <= eTnew_d;
      mA3_q   <= mA3_d;
      mTnew_q <= mTnew_d;
    end
  end

  assign bus.Stall_Data = stall;
  assign bus.md_busy    = mdBusy;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: register-hazard vector table plus mult/div and reset sequences.
module tb_hazard_stall_unit;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  hazard_stall_unit_if #(.REG_W(5)) bus ();

  hazard_stall_unit #(
    .REG_W      (5),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Each record loads one producer into E, then checks D against it in E and again one cycle later in M.
  typedef struct {
    logic [4:0] preA3;
    logic [1:0] preTnew;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [1:0] tuseRs;
    logic [1:0] tuseRt;
    logic       expE;
    logic       expM;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s[%0d]: got %b, wanted %b", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] a1, input logic [4:0] a2,
                               input logic [1:0] tuseRs, input logic [1:0] tuseRt,
                               input logic [4:0] a3, input logic [1:0] tnew,
                               input logic isMd, input logic mdStart, input logic mdDiv);
    bus.D_A1        = a1;
    bus.D_A2        = a2;
    bus.D_Tuse_rs   = tuseRs;
    bus.D_Tuse_rt   = tuseRt;
    bus.D_A3        = a3;
    bus.D_Tnew      = tnew;
    bus.D_is_md     = isMd;
    bus.E_md_start  = mdStart;
    bus.E_md_is_div = mdDiv;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{5'd1,  2'd2, 5'd1,  5'd0,  2'd1, 2'd3, 1'b1, 1'b0};
    vecs[1]  = '{5'd2,  2'd1, 5'd0,  5'd2,  2'd3, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{5'd2,  2'd1, 5'd0,  5'd2,  2'd3, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{5'd0,  2'd2, 5'd0,  5'd0,  2'd0, 2'd3, 1'b0, 1'b0};
    vecs[4]  = '{5'd5,  2'd2, 5'd5,  5'd0,  2'd3, 2'd3, 1'b0, 1'b0};
    vecs[5]  = '{5'd5,  2'd2, 5'd6,  5'd0,  2'd0, 2'd3, 1'b0, 1'b0};
    vecs[6]  = '{5'd7,  2'd2, 5'd7,  5'd0,  2'd0, 2'd3, 1'b1, 1'b1};
    vecs[7]  = '{5'd9,  2'd2, 5'd0,  5'd9,  2'd3, 2'd0, 1'b1, 1'b1};
    vecs[8]  = '{5'd31, 2'd2, 5'd31, 5'd31, 2'd2, 2'd2, 1'b0, 1'b0};
    vecs[9]  = '{5'd12, 2'd1, 5'd12, 5'd12, 2'd0, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{5'd4,  2'd0, 5'd4,  5'd0,  2'd0, 2'd3, 1'b0, 1'b0};

    // Outputs must stay low while reset is held, even with an md start and md instruction present.
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #12;
    checkOutput("resetStall", 0, bus.Stall_Data, 1'b0);
    checkOutput("resetBusy", 0, bus.md_busy, 1'b0);

    for (int i = 0; i < 11; i++) begin
      resetDut();
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, vecs[i].preA3, vecs[i].preTnew, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("loadStall", i, bus.Stall_Data, 1'b0);
      nextCycle();
      applyStimulus(vecs[i].a1, vecs[i].a2, vecs[i].tuseRs, vecs[i].tuseRt,
                    5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("stallVsE", i, bus.Stall_Data, vecs[i].expE);
      nextCycle();
      checkOutput("stallVsM", i, bus.Stall_Data, vecs[i].expM);
    end

    // Mult window: busy in the start cycle and five more.
    resetDut();
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, (c == 0), 1'b0);
      #1;
      checkOutput("multStall", c, bus.Stall_Data, (c <= 5));
      checkOutput("multBusy", c, bus.md_busy, (c <= 5));
      nextCycle();
    end

    // Div window: busy in the start cycle and ten more.
    resetDut();
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, (c == 0), 1'b1);
      #1;
      checkOutput("divStall", c, bus.Stall_Data, (c <= 10));
      nextCycle();
    end

    // Div at cycle 0, mult restart at cycle 4 (count 7 -> 5): busy ends after cycle 9.
    resetDut();
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, (c == 0) || (c == 4), (c == 0));
      #1;
      if (c >= 4) checkOutput("restartBusy", c, bus.md_busy, (c <= 9));
      nextCycle();
    end

    // Async reset mid-div with a producer in E; no clock edge between assert and check.
    resetDut();
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, (c == 6) ? 5'd3 : 5'd0, (c == 6) ? 2'd2 : 2'd0,
                    1'b0, (c == 0), 1'b1);
      nextCycle();
    end
    applyStimulus(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("preRstStall", 0, bus.Stall_Data, 1'b1);
    checkOutput("preRstBusy", 0, bus.md_busy, 1'b1);
    checkOutput("preRstCnt", 0, (dut.u_cnt.mdCnt_q == 4'd4), 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("asyncStall", 0, bus.Stall_Data, 1'b0);
    checkOutput("asyncBusy", 0, bus.md_busy, 1'b0);
    checkOutput("asyncCnt", 0, (dut.u_cnt.mdCnt_q == 4'd0), 1'b1);
    checkOutput("asyncEA3", 0, (dut.eA3_q == 5'd0), 1'b1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("postRstStall", 0, bus.Stall_Data, 1'b0);
    checkOutput("postRstBusy", 0, bus.md_busy, 1'b0);
    nextCycle();
    checkOutput("postRstStall", 1, bus.Stall_Data, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall source for the five-stage pipeline: decides each cycle whether the D-stage instruction must be held and a bubble inserted into E.
- Drives the single Stall_Data signal consumed by the PC/D-register enable and E-register clear logic.
- Tracks the write-register and Tnew of the instructions in E and M internally, using Tuse/Tnew comparison.
- Contains the multiply/divide busy counter, so HI/LO instructions stall while a mult/div is in flight.

Parameters:
REG_W, 5, register-address width
MULT_CYCLES, 5, busy cycles after mult/multu enters E
DIV_CYCLES, 10, busy cycles after div/divu enters E
CNT_W, 4, busy-counter width; must hold DIV_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
D_A1  input  REG_W  rs address of D-stage instruction
D_A2  input  REG_W  rt address of D-stage instruction
D_Tuse_rs  input  2  cycles until rs is needed; 3 = rs not read
D_Tuse_rt  input  2  cycles until rt is needed; 3 = rt not read
D_A3  input  REG_W  destination register of D-stage instruction; 0 = none
D_Tnew  input  2  cycles until result is forwardable once in E; 0..2
D_is_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
E_md_start  input  1  mult/div currently in E (start pulse, one cycle)
E_md_is_div  input  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
Stall_Data  output  1  1 = hold PC and D, clear E this cycle
md_busy  output  1  mult/div unit busy (E_md_start or counter non-zero)

Behaviour:
- Clock and reset: clk, reset; the reset is asynchronous, active-high.
- State registers:
  - E_A3, E_Tnew: shadow of the E stage.
  - M_A3, M_Tnew: shadow of the M stage.
  - md_cnt: busy counter, CNT_W bits.
- Reset values: all state registers = 0. While reset is high, Stall_Data = 0 and md_busy = 0, regardless of inputs.
- Stall_Data is combinational from the current state and D inputs, with zero-cycle latency. It is the OR of:
  - rs hazard vs E: D_Tuse_rs < E_Tnew && D_A1 == E_A3 && E_A3 != 0
  - rt hazard vs E: same form with D_Tuse_rt / D_A2
  - rs hazard vs M: D_Tuse_rs < M_Tnew && D_A1 == M_A3 && M_A3 != 0
  - rt hazard vs M: D_Tuse_rt < M_Tnew && D_A2 == M_A3 && M_A3 != 0
  - md hazard: D_is_md && md_busy
- Tuse = 3 never stalls, because Tnew is at most 2.
- Register 0 never causes a hazard.
- Shadow-pipeline update on every rising edge (no enable):
  - If Stall_Data = 1: E_A3 <= 0, E_Tnew <= 0 (bubble).
  - Else: E_A3 <= D_A3, E_Tnew <= D_Tnew.
  - Always: M_A3 <= E_A3; M_Tnew <= max(E_Tnew − 1, 0), saturating at 0.
- md_busy = E_md_start || (md_cnt != 0), combinational.
- Busy-counter update on every edge, in priority order:
  - If E_md_start: md_cnt <= (E_md_is_div ? DIV_CYCLES : MULT_CYCLES). A start while md_cnt != 0 reloads the counter (restart, no accumulation).
  - Else if md_cnt != 0: md_cnt <= md_cnt − 1.
  - Else: hold at 0 (no underflow).
- Busy window: a mult starting in cycle t keeps md_busy = 1 for cycles t..t+MULT_CYCLES. md_busy is first 0 in cycle t+MULT_CYCLES+1.
- Simultaneous register and md hazards give a single Stall_Data = 1. There is no priority, because the output is a pure OR.
- Reset asserted mid-stall or mid-mult: all state clears immediately. After reset is released, no stale hazard remains.

Decomposition:
- Shared package (macro include): TUSE_NONE = 2'd3; Tnew encodings; MULT_CYCLES/DIV_CYCLES defaults; REG_W.
- One natural sub-module, md_busy_counter: the counter, md_busy and load/decrement logic, with ports clk, reset, start, is_div, busy.
- Hazard compare and shadow registers stay in the top module.

Test Plan:
- Load-use: lw $1 in E (E_A3=1, E_Tnew=2), D reads $1 with D_Tuse_rs=1:
  - Stall_Data=1 for exactly 1 cycle.
  - Next cycle E is a bubble (E_A3=0) and M_Tnew=1 → Stall_Data=0.
- Forwardable ALU result: addu $2 in E (Tnew=1), D has D_A2=2, D_Tuse_rt=1 → Stall_Data=0. Same case with D_Tuse_rt=0 → Stall_Data=1 for 1 cycle.
- $0 and unused operands: E_A3=0, E_Tnew=2, D_A1=0, D_Tuse_rs=0 → Stall_Data=0. D_Tuse_rs=3 with a matching address → Stall_Data=0.
- Mult busy window: E_md_start=1, E_md_is_div=0 at cycle 0; D_is_md=1 held throughout:
  - Stall_Data=1 in cycles 0..5.
  - Stall_Data=0 at cycle 6.
  - Div variant: Stall_Data=1 in cycles 0..10, 0 at cycle 11.
- Restart: div started, then E_md_start=1 (mult) while md_cnt=7 → md_cnt reloads to 5 and counts down from there.
- Async reset: assert reset mid-div (md_cnt=4) and with E_A3=3, E_Tnew=2, independent of clk:
  - md_busy=0, Stall_Data=0, all state 0 immediately.
  - After release, with D_A1=3, D_Tuse_rs=0 → Stall_Data=0.
